// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship game controller: FSM states,
// status-word codes and seven-segment glyphs.
package battleship_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_TURN_A = 3'd1,
    ST_TURN_B = 3'd2,
    ST_WIN_A  = 3'd3,
    ST_WIN_B  = 3'd4
  } state_e;

  localparam logic [2:0] DISP_LOAD = 3'd0;
  localparam logic [2:0] DISP_FIRE = 3'd1;
  localparam logic [2:0] DISP_HOLD = 3'd2;
  localparam logic [2:0] DISP_WIN  = 3'd3;
  localparam logic [2:0] DISP_LOSE = 3'd4;

  // Lit-segment masks, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] GLY_L     = 7'h38;
  localparam logic [6:0] GLY_O     = 7'h3F;
  localparam logic [6:0] GLY_A     = 7'h77;
  localparam logic [6:0] GLY_D     = 7'h5E;
  localparam logic [6:0] GLY_F     = 7'h71;
  localparam logic [6:0] GLY_I     = 7'h30;
  localparam logic [6:0] GLY_R     = 7'h50;
  localparam logic [6:0] GLY_E     = 7'h79;
  localparam logic [6:0] GLY_H     = 7'h76;
  localparam logic [6:0] GLY_G     = 7'h3D;
  localparam logic [6:0] GLY_S     = 7'h6D;
  localparam logic [6:0] GLY_BLANK = 7'h00;

  // Glyph of a word at digit position pos (0 = rightmost character)
  function automatic logic [6:0] word_glyph(input logic [2:0] code, input logic [1:0] pos);
    logic [27:0] word;
    case (code)
      DISP_LOAD: word = {GLY_L, GLY_O, GLY_A, GLY_D};
      DISP_FIRE: word = {GLY_F, GLY_I, GLY_R, GLY_E};
      DISP_HOLD: word = {GLY_H, GLY_O, GLY_L, GLY_D};
      DISP_WIN:  word = {GLY_G, GLY_O, GLY_O, GLY_D};
      DISP_LOSE: word = {GLY_L, GLY_O, GLY_S, GLY_E};
      default:   word = {4{GLY_BLANK}};
    endcase
    case (pos)
      2'd0:    return word[6:0];
      2'd1:    return word[13:7];
      2'd2:    return word[20:14];
      default: return word[27:21];
    endcase
  endfunction

endpackage

// File: rtl/battleship_word_disp.sv
// Four-digit multiplexed seven-segment renderer for one status word.
// The scan counter's top two bits pick the active digit.
module battleship_word_disp
  import battleship_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] word_sel,
  output logic [7:0] seg,
  output logic [3:0] an
);

  logic [REFRESH_BITS-1:0] cnt_q;
  logic [REFRESH_BITS-1:0] cnt_d;
  logic [1:0]              idx;

  always_comb begin
    cnt_d = cnt_q + REFRESH_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Digit select and glyph lookup stay combinational so word changes show at once
  always_comb begin
    idx = cnt_q[REFRESH_BITS-1 -: 2];
    an  = ~(4'b0001 << idx);
    seg = {1'b1, ~word_glyph(word_sel, idx)};
  end

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship turn-sequencing FSM with button edge detection, driving register
// load strobes, status words and player A's seven-segment display.
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn1,
  input  logic       btn2a,
  input  logic       btn2b,
  input  logic       liv_a,
  input  logic       liv_b,
  input  logic       ok_a,
  input  logic       ok_b,
  output logic       ldr1a,
  output logic       ldr1b,
  output logic       ldr2a,
  output logic       ldr2b,
  output logic       st,
  output logic [2:0] disp_a,
  output logic [2:0] disp_b,
  output logic [7:0] seg,
  output logic [3:0] an
);

  state_e state_q, state_d;
  logic   btn1_q, btn2a_q, btn2b_q;
  logic   rise1, rise2a, rise2b;

  always_comb begin
    rise1  = btn1  & ~btn1_q;
    rise2a = btn2a & ~btn2a_q;
    rise2b = btn2b & ~btn2b_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_LOAD;
      btn1_q  <= 1'b0;
      btn2a_q <= 1'b0;
      btn2b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      btn1_q  <= btn1;
      btn2a_q <= btn2a;
      btn2b_q <= btn2b;
    end
  end

  // Next state, Moore status words and Mealy attack strobes; liv_b is checked first
  always_comb begin
    state_d = state_q;
    st      = 1'b1;
    ldr1a   = 1'b0;
    ldr1b   = 1'b0;
    ldr2a   = 1'b0;
    ldr2b   = 1'b0;
    disp_a  = DISP_LOAD;
    disp_b  = DISP_LOAD;
    case (state_q)
      ST_LOAD: begin
        st    = 1'b0;
        ldr1a = 1'b1;
        ldr1b = 1'b1;
        if (rise1) state_d = ST_TURN_A;
      end
      ST_TURN_A: begin
        disp_a = DISP_FIRE;
        disp_b = DISP_HOLD;
        if (!liv_b)                state_d = ST_WIN_A;
        else if (!liv_a)           state_d = ST_WIN_B;
        else if (rise2a && ok_a) begin
          ldr2a   = 1'b1;
          state_d = ST_TURN_B;
        end
      end
      ST_TURN_B: begin
        disp_a = DISP_HOLD;
        disp_b = DISP_FIRE;
        if (!liv_b)                state_d = ST_WIN_A;
        else if (!liv_a)           state_d = ST_WIN_B;
        else if (rise2b && ok_b) begin
          ldr2b   = 1'b1;
          state_d = ST_TURN_A;
        end
      end
      ST_WIN_A: begin
        disp_a = DISP_WIN;
        disp_b = DISP_LOSE;
      end
      ST_WIN_B: begin
        disp_a = DISP_LOSE;
        disp_b = DISP_WIN;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  battleship_word_disp #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_disp (
    .clk      (clk),
    .clr      (clr),
    .word_sel (disp_a),
    .seg      (seg),
    .an       (an)
  );

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl: a word/glyph-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_battleship_game_ctrl;

  localparam int unsigned RB = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       btn1 = 1'b0, btn2a = 1'b0, btn2b = 1'b0;
  logic       liv_a = 1'b1, liv_b = 1'b1, ok_a = 1'b1, ok_b = 1'b1;
  logic       ldr1a, ldr1b, ldr2a, ldr2b, st;
  logic [2:0] disp_a, disp_b;
  logic [7:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  battleship_game_ctrl #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .clr(clr), .btn1(btn1), .btn2a(btn2a), .btn2b(btn2b),
    .liv_a(liv_a), .liv_b(liv_b), .ok_a(ok_a), .ok_b(ok_b),
    .ldr1a(ldr1a), .ldr1b(ldr1b), .ldr2a(ldr2a), .ldr2b(ldr2b), .st(st),
    .disp_a(disp_a), .disp_b(disp_b), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_LOAD = 0, M_TA = 1, M_TB = 2, M_WA = 3, M_WB = 4;
  int   m_state = M_LOAD;
  int   m_cnt   = 0;
  bit   m_valid = 1'b0;
  logic m_p1 = 1'b0, m_p2a = 1'b0, m_p2b = 1'b0;

  function automatic string word_of(input int code);
    case (code)
      0: return "LOAd";
      1: return "FIrE";
      2: return "HOLd";
      3: return "GOOd";
      4: return "LOSE";
      default: return "    ";
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input byte ch);
    string lit;
    logic [7:0] s;
    case (ch)
      "L": lit = "def";    "O": lit = "abcdef"; "A": lit = "abcefg";
      "d": lit = "bcdeg";  "F": lit = "aefg";   "I": lit = "ef";
      "r": lit = "eg";     "E": lit = "adefg";  "H": lit = "bcefg";
      "G": lit = "acdef";  "S": lit = "acdfg";  default: lit = "";
    endcase
    s = 8'hFF;
    for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
    return s;
  endfunction

  function automatic int exp_da(input int s);
    case (s)
      M_TA: return 1; M_TB: return 2; M_WA: return 3; M_WB: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_db(input int s);
    case (s)
      M_TA: return 2; M_TB: return 1; M_WA: return 4; M_WB: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_state = M_LOAD;
      m_cnt   = 0;
      m_p1 = 1'b0; m_p2a = 1'b0; m_p2b = 1'b0;
      m_valid = 1'b1;
    end else begin
      case (m_state)
        M_LOAD: if (btn1 && !m_p1) m_state = M_TA;
        M_TA: begin
          if (!liv_b) m_state = M_WA;
          else if (!liv_a) m_state = M_WB;
          else if (btn2a && !m_p2a && ok_a) m_state = M_TB;
        end
        M_TB: begin
          if (!liv_b) m_state = M_WA;
          else if (!liv_a) m_state = M_WB;
          else if (btn2b && !m_p2b && ok_b) m_state = M_TA;
        end
        default: ;
      endcase
      m_p1 = btn1; m_p2a = btn2a; m_p2b = btn2b;
      m_cnt = (m_cnt + 1) % (1 << RB);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      int idx;
      string w;
      logic e2a, e2b;
      idx = m_cnt >> (RB - 2);
      w   = word_of(exp_da(m_state));
      e2a = (m_state == M_TA) && liv_b && liv_a && btn2a && !m_p2a && ok_a;
      e2b = (m_state == M_TB) && liv_b && liv_a && btn2b && !m_p2b && ok_b;
      chk("st",     32'(st),     32'(m_state != M_LOAD));
      chk("ldr1a",  32'(ldr1a),  32'(m_state == M_LOAD));
      chk("ldr1b",  32'(ldr1b),  32'(m_state == M_LOAD));
      chk("ldr2a",  32'(ldr2a),  32'(e2a));
      chk("ldr2b",  32'(ldr2b),  32'(e2b));
      chk("disp_a", 32'(disp_a), 32'(exp_da(m_state)));
      chk("disp_b", 32'(disp_b), 32'(exp_db(m_state)));
      chk("an",     32'(an),     32'(4'hF & ~(4'h1 << idx)));
      chk("seg",    32'(seg),    32'(seg_of(w[3 - idx])));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(2);
    clr = 1'b0;
    chk("rst_st",    32'(st),     32'h0);
    chk("rst_ldr1a", 32'(ldr1a),  32'h1);
    chk("rst_ldr1b", 32'(ldr1b),  32'h1);
    chk("rst_ldr2",  32'({ldr2a, ldr2b}), 32'h0);
    chk("rst_disp",  32'({disp_a, disp_b}), 32'h0);
    chk("rst_an",    32'(an),     32'hE);
    chk("rst_seg",   32'(seg),    32'hA1);
    tick(4);
    chk("scan1_an",  32'(an),  32'hD);
    chk("scan1_seg", 32'(seg), 32'h88);
    tick(4);
    chk("scan2_an",  32'(an),  32'hB);
    chk("scan2_seg", 32'(seg), 32'hC0);
    tick(4);
    chk("scan3_an",  32'(an),  32'h7);
    chk("scan3_seg", 32'(seg), 32'hC7);

    // Start: btn1 held 5 cycles
    btn1 = 1'b1;
    tick(1);
    chk("start_st",     32'(st),     32'h1);
    chk("start_disp_a", 32'(disp_a), 32'h1);
    chk("start_disp_b", 32'(disp_b), 32'h2);
    tick(4);
    btn1 = 1'b0;
    chk("start_hold", 32'(disp_a), 32'h1);

    // B's button is ignored in A's turn
    btn2b = 1'b1;
    tick(1);
    btn2b = 1'b0;
    chk("ta_ign_b", 32'(disp_a), 32'h1);

    // Illegal attack: no strobe
    ok_a = 1'b0; btn2a = 1'b1;
    #1;
    chk("ta_illegal_ldr2a", 32'(ldr2a), 32'h0);
    tick(1);
    btn2a = 1'b0;
    tick(1);
    chk("ta_illegal_stay", 32'(disp_a), 32'h1);

    // Legal attack: one-cycle strobe, then B's turn
    ok_a = 1'b1; btn2a = 1'b1;
    #1;
    chk("ta_fire_ldr2a", 32'(ldr2a), 32'h1);
    tick(1);
    chk("tb_ldr2a_off", 32'(ldr2a),  32'h0);
    chk("tb_disp_a",    32'(disp_a), 32'h2);
    chk("tb_disp_b",    32'(disp_b), 32'h1);

    // B fires back while A keeps holding btn2a
    btn2b = 1'b1;
    #1;
    chk("tb_fire_ldr2b", 32'(ldr2b), 32'h1);
    tick(1);
    chk("ta_again", 32'(disp_a), 32'h1);
    chk("ta_held_no_fire", 32'(ldr2a), 32'h0);
    tick(2);
    chk("ta_held_stay", 32'(disp_a), 32'h1);
    btn2a = 1'b0; btn2b = 1'b0;
    tick(1);

    // Back to B's turn, then A loses all ships
    btn2a = 1'b1;
    tick(1);
    btn2a = 1'b0;
    liv_a = 1'b0;
    tick(1);
    chk("winb_disp_a", 32'(disp_a), 32'h4);
    chk("winb_disp_b", 32'(disp_b), 32'h3);
    btn1 = 1'b1; btn2a = 1'b1; btn2b = 1'b1; liv_a = 1'b1;
    tick(2);
    chk("winb_stay", 32'(disp_a), 32'h4);
    chk("winb_no_strobe", 32'({ldr2a, ldr2b}), 32'h0);
    btn1 = 1'b0; btn2a = 1'b0; btn2b = 1'b0;

    // Restart, both players dead in A's turn: liv_b wins priority
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    btn1 = 1'b1;
    tick(1);
    btn1 = 1'b0;
    liv_a = 1'b0; liv_b = 1'b0;
    tick(1);
    chk("wina_disp_a", 32'(disp_a), 32'h3);
    chk("wina_disp_b", 32'(disp_b), 32'h4);

    // Clear mid-scan; LOAD ignores liveness
    tick(5);
    clr = 1'b1;
    tick(1);
    chk("clr_an",     32'(an),     32'hE);
    chk("clr_st",     32'(st),     32'h0);
    chk("clr_disp_a", 32'(disp_a), 32'h0);
    clr = 1'b0;
    tick(3);
    chk("load_ign_liv", 32'(st), 32'h0);
    chk("load_ldr1a",   32'(ldr1a), 32'h1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
